led_string_serializer: RTL and testbench
========================================

LED_STRING_SERIALIZER -- requirements
Module: led_string_serializer

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 Parameter T0H_CYCLES, default 8: clk cycles sdi is high for a 0 bit (0.4 us at 20 MHz).
REQ-003 Parameter T1H_CYCLES, default 16: clk cycles sdi is high for a 1 bit (0.8 us).
REQ-004 Parameter BIT_CYCLES, default 25: total clk cycles per bit (1.25 us); must exceed T1H_CYCLES.
REQ-005 Parameter LATCH_CYCLES, default 1200: sdi-low cycles that end a frame (60 us).
REQ-006 Parameter N_LEDS, default 236: pixels per frame.
REQ-007 Port clk  input  1  system clock (20 MHz domain).
REQ-008 Port reset  input  1  synchronous active-high reset.
REQ-009 Port pixel_data  input  24  GRB pixel, MSB first on the wire.
REQ-010 Port pixel_valid  input  1  pixel_data is valid.
REQ-011 Port pixel_ready  output  1  serializer accepts pixel_data this cycle.
REQ-012 Port latch_req  input  1  single-cycle request to end the frame early (h_blank).
REQ-013 Port sdi  output  1  serial data to the LED string.
REQ-014 Port busy  output  1  high in any state other than IDLE.
REQ-015 Port frame_done  output  1  one-cycle pulse when LATCH completes.
REQ-016 Port pixel_count  output  9  pixels sent in the current frame.
REQ-017 Port underrun_count  output  16  saturating count of mid-frame underruns.

Function
REQ-018 States SHALL be IDLE, HIGH, LOW and LATCH.
REQ-019 A transfer SHALL occur when pixel_valid and pixel_ready are both high on a rising clk edge.
REQ-020 pixel_ready SHALL be high in IDLE, and in the last LOW cycle of bit 0 when pixel_count+1 < N_LEDS and no latch is pending; otherwise low.
REQ-021 On transfer, the 24-bit shift register SHALL load, bit index SHALL reset to 23, the state SHALL become HIGH, and sdi SHALL go high on the next cycle (one-cycle latency).
REQ-022 HIGH SHALL last T1H_CYCLES for a 1 bit and T0H_CYCLES for a 0 bit, with sdi=1.
REQ-023 LOW SHALL last the remainder of BIT_CYCLES, with sdi=0.
REQ-024 At the end of LOW, the next bit SHALL start in HIGH when bits remain; a transfer at that edge SHALL start bit 23 of the new pixel with no gap.
REQ-025 pixel_count SHALL increment by one at the end of bit 0 of each pixel.
REQ-026 When pixel_count reaches N_LEDS, the state SHALL become LATCH.
REQ-027 When no pixel is transferred at the end of bit 0, the state SHALL become IDLE and count one underrun.
REQ-028 latch_req in IDLE with pixel_count>0 SHALL enter LATCH on the next cycle.
REQ-029 latch_req in IDLE with pixel_count==0 SHALL be ignored.
REQ-030 latch_req in HIGH or LOW SHALL be held pending; the current pixel SHALL complete, then the state SHALL enter LATCH.
REQ-031 In LATCH, sdi SHALL be 0 for exactly LATCH_CYCLES cycles.
REQ-032 On leaving LATCH, frame_done SHALL pulse for one cycle, pixel_count SHALL clear, the pending latch SHALL clear, and the state SHALL become IDLE.
REQ-033 latch_req during LATCH SHALL be ignored.
REQ-034 A transfer in the same cycle as latch_req in IDLE SHALL take priority; the latch SHALL then be pending.

Reset
REQ-035 Reset SHALL set state IDLE, sdi=0, busy=0, frame_done=0, pixel_count=0, underrun_count=0, all timers=0 and latch pending=0.
REQ-036 Reset asserted mid-bit or mid-latch SHALL take effect at the next edge, with sdi=0 on the following cycle.
REQ-037 pixel_ready SHALL be 0 while reset is high.

Configuration
REQ-038 With LED_SER_UNDERRUN_CNT_EN defined, underrun_count SHALL increment, saturating at 16'hFFFF, on each underrun (IDLE entry with 0<pixel_count<N_LEDS), and SHALL clear on reset only.
REQ-039 Without LED_SER_UNDERRUN_CNT_EN, underrun_count SHALL be tied to 0 and no counter logic SHALL be built.
REQ-040 In both configurations, state behaviour SHALL be identical.

Verification
REQ-041 Single pixel 24'h800000, then latch_req: sdi high 16 cycles, low 9; then 23 bits each high 8, low 17; LATCH 1200 cycles low; frame_done pulses once; pixel_count returns to 0.
REQ-042 N_LEDS=4 with pixel_valid held high: 4×24×25=2400 contiguous bit cycles with no gaps, then automatic LATCH, frame_done, and pixel_count=4 just before clear.
REQ-043 latch_req pulsed during bit 10 of pixel 2: pixel 2 completes all 24 bits, then LATCH; no third pixel is accepted.
REQ-044 Underrun: pixel_valid drops after pixel 1 of N_LEDS=4: IDLE with pixel_count=1, busy=0; underrun_count=1 with the macro defined and 0 without; resuming pixels continues the frame.
REQ-045 Reset asserted in cycle 5 of HIGH: sdi=0 and state IDLE next cycle; pixel_count=0; the subsequent pixel transmits normally.
REQ-046 latch_req with pixel_count=0 in IDLE: no LATCH, no frame_done, busy stays 0.

Source files
------------

// File: rtl/led_string_serializer.sv
`timescale 1ns/1ps
// Single-wire LED string serializer: 24-bit GRB pixels, MSB first, with end-of-frame latch.
// Define LED_SER_UNDERRUN_CNT_EN to build the saturating underrun counter.
module led_string_serializer #(
    parameter int T0H_CYCLES   = 8,
    parameter int T1H_CYCLES   = 16,
    parameter int BIT_CYCLES   = 25,
    parameter int LATCH_CYCLES = 1200,
    parameter int N_LEDS       = 236
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        latch_req,
    output logic        sdi,
    output logic        busy,
    output logic        frame_done,
    output logic [8:0]  pixel_count,
    output logic [15:0] underrun_count
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    localparam int TMAX = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] high_last;
    logic [23:0]   shreg;
    logic [4:0]    bit_idx;
    logic          latch_pend;
    logic          xfer, high_end, bit_end, latch_end, pixel_end, last_pixel;

    // One timer spans the whole bit (HIGH then LOW), or the whole latch gap.
    assign high_last  = shreg[23] ? TW'(T1H_CYCLES - 1) : TW'(T0H_CYCLES - 1);
    assign high_end   = (timer == high_last);
    assign bit_end    = (timer == TW'(BIT_CYCLES - 1));
    assign latch_end  = (timer == TW'(LATCH_CYCLES - 1));
    assign pixel_end  = (state == LOW) && bit_end && (bit_idx == 5'd0);
    assign last_pixel = (({1'b0, pixel_count} + 10'd1) >= 10'(N_LEDS));
    assign xfer       = pixel_valid && pixel_ready;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (xfer)                                 state_nxt = HIGH;
                else if (latch_req && pixel_count != 9'd0) state_nxt = LATCH;
            end
            HIGH: if (high_end) state_nxt = LOW;
            LOW: begin
                if (bit_end) begin
                    if (bit_idx != 5'd0)               state_nxt = HIGH;
                    else if (last_pixel || latch_pend) state_nxt = LATCH;
                    else if (xfer)                     state_nxt = HIGH;
                    else                               state_nxt = IDLE;
                end
            end
            LATCH: if (latch_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pixel_ready = 1'b0;
        sdi         = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy        = 1'b0;
                pixel_ready = !reset;
            end
            HIGH: sdi = 1'b1;
            LOW:  pixel_ready = !reset && pixel_end && !last_pixel && !latch_pend;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer       <= '0;
            bit_idx     <= '0;
            pixel_count <= '0;
            latch_pend  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (xfer) begin
                        bit_idx <= 5'd23;
                        if (latch_req) latch_pend <= 1'b1;
                    end
                end
                HIGH: begin
                    timer <= timer + TW'(1);
                    if (latch_req) latch_pend <= 1'b1;
                end
                LOW: begin
                    if (latch_req) latch_pend <= 1'b1;
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx != 5'd0) begin
                            bit_idx <= bit_idx - 5'd1;
                        end else begin
                            pixel_count <= pixel_count + 9'd1;
                            if (xfer) bit_idx <= 5'd23;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                LATCH: begin
                    if (latch_end) begin
                        timer       <= '0;
                        frame_done  <= 1'b1;
                        pixel_count <= '0;
                        latch_pend  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: timer <= '0;
            endcase
        end
    end

    // Pixel shift register is pure data; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (xfer)
            shreg <= pixel_data;
        else if (state == LOW && bit_end && bit_idx != 5'd0)
            shreg <= {shreg[22:0], 1'b0};
    end

`ifdef LED_SER_UNDERRUN_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic underrun;
    assign underrun = pixel_end && !last_pixel && !latch_pend && !xfer;

    always_ff @(posedge clk) begin
        if (reset)         underrun_count <= '0;
        else if (underrun) underrun_count <= sat_inc16(underrun_count);
    end
`else
    assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_led_string_serializer.sv
`timescale 1ns/1ps
// Directed bench for led_string_serializer with N_LEDS=4 and default bit/latch timing.
module tb_led_string_serializer;
    localparam int T0H   = 8;
    localparam int T1H   = 16;
    localparam int BITC  = 25;
    localparam int LATC  = 1200;
    localparam int NLEDS = 4;
`ifdef LED_SER_UNDERRUN_CNT_EN
    localparam int UR_STEP = 1;
`else
    localparam int UR_STEP = 0;
`endif

    logic        clk;
    logic        reset;
    logic [23:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        latch_req;
    logic        sdi;
    logic        busy;
    logic        frame_done;
    logic [8:0]  pixel_count;
    logic [15:0] underrun_count;

    int n_checks = 0;
    int n_fail   = 0;

    led_string_serializer #(
        .T0H_CYCLES  (T0H),
        .T1H_CYCLES  (T1H),
        .BIT_CYCLES  (BITC),
        .LATCH_CYCLES(LATC),
        .N_LEDS      (NLEDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .latch_req     (latch_req),
        .sdi           (sdi),
        .busy          (busy),
        .frame_done    (frame_done),
        .pixel_count   (pixel_count),
        .underrun_count(underrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered in the first HIGH cycle of px; leaves one cycle after its final edge.
    task automatic check_pixel(input logic [23:0] px, input logic exp_rdy, input logic nv,
                               input logic [23:0] npx, input int lreq_b, input string tag);
        int bad = 0;
        int th;
        for (int b = 0; b < 24; b++) begin
            th = px[23-b] ? T1H : T0H;
            for (int c = 0; c < BITC; c++) begin
                latch_req = (b == lreq_b) && (c == 3);
                if (sdi !== logic'(c < th)) bad++;
                if (b == 23 && c == BITC - 1) begin
                    chk({tag, "_rdy"}, pixel_ready, exp_rdy);
                    pixel_valid = nv;
                    pixel_data  = npx;
                end
                tick();
            end
        end
        latch_req = 1'b0;
        chk({tag, "_wave"}, bad, 0);
    endtask

    // Entered in the first LATCH cycle; leaves in IDLE after the frame_done pulse.
    task automatic run_latch(input string tag);
        int n = 0;
        int bad = 0;
        while (busy && n < 2000) begin
            if (sdi !== 1'b0 || frame_done !== 1'b0) bad++;
            n++;
            tick();
        end
        chk({tag, "_len"}, n, LATC);
        chk({tag, "_quiet"}, bad, 0);
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_cnt_clr"}, pixel_count, 0);
        pixel_valid = 1'b0;
        tick();
        chk({tag, "_done_off"}, frame_done, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int fd;
        reset       = 1'b1;
        pixel_data  = '0;
        pixel_valid = 1'b0;
        latch_req   = 1'b0;
        tick(); tick(); tick();
        chk("rst_rdy", pixel_ready, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_cnt", pixel_count, 0);
        chk("rst_ur", underrun_count, 0);
        reset = 1'b0;
        tick();
        chk("idle_rdy", pixel_ready, 1);

        // Single pixel; latch_req arrives with the transfer and waits for the pixel.
        pixel_data  = 24'h800000;
        pixel_valid = 1'b1;
        latch_req   = 1'b1;
        tick();
        pixel_valid = 1'b0;
        latch_req   = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_rdy_mid", pixel_ready, 0);
        check_pixel(24'h800000, 1'b0, 1'b0, 24'h0, -1, "t1_px");
        chk("t1_latch_busy", busy, 1);
        chk("t1_cnt", pixel_count, 1);
        run_latch("t1");

        // latch_req with an empty frame is ignored.
        latch_req = 1'b1;
        tick();
        latch_req = 1'b0;
        fd = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy !== 1'b0 || frame_done !== 1'b0) fd++;
            tick();
        end
        chk("t6_ignored", fd, 0);

        // Full frame of four back-to-back pixels, then automatic latch.
        pixel_data  = 24'hA50FC3;
        pixel_valid = 1'b1;
        tick();
        check_pixel(24'hA50FC3, 1'b1, 1'b1, 24'h000001, -1, "t2_p0");
        chk("t2_cnt1", pixel_count, 1);
        check_pixel(24'h000001, 1'b1, 1'b1, 24'hFFFFFF, -1, "t2_p1");
        chk("t2_cnt2", pixel_count, 2);
        check_pixel(24'hFFFFFF, 1'b1, 1'b1, 24'h123456, -1, "t2_p2");
        check_pixel(24'h123456, 1'b0, 1'b1, 24'h5A5A5A, -1, "t2_p3");
        chk("t2_cnt4", pixel_count, 4);
        chk("t2_latch_busy", busy, 1);
        run_latch("t2");

        // latch_req during bit 10 of pixel 2 ends the frame after that pixel.
        pixel_data  = 24'h3C3C3C;
        pixel_valid = 1'b1;
        tick();
        check_pixel(24'h3C3C3C, 1'b1, 1'b1, 24'hC0FFEE, -1, "t3_p0");
        check_pixel(24'hC0FFEE, 1'b0, 1'b1, 24'h777777, 13, "t3_p1");
        chk("t3_cnt2", pixel_count, 2);
        chk("t3_latch_busy", busy, 1);
        run_latch("t3");

        // Underruns mid-frame, then latch_req from IDLE closes the frame.
        pixel_data  = 24'h00FF00;
        pixel_valid = 1'b1;
        tick();
        check_pixel(24'h00FF00, 1'b1, 1'b0, 24'h0, -1, "t4_p0");
        chk("t4_ur_busy", busy, 0);
        chk("t4_ur_cnt", pixel_count, 1);
        chk("t4_ur1", underrun_count, UR_STEP);
        pixel_data  = 24'h0000F0;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        check_pixel(24'h0000F0, 1'b1, 1'b0, 24'h0, -1, "t4_p1");
        chk("t4_resume_cnt", pixel_count, 2);
        chk("t4_ur2", underrun_count, 2 * UR_STEP);
        latch_req = 1'b1;
        tick();
        latch_req = 1'b0;
        chk("t4_latch_busy", busy, 1);
        run_latch("t4");

        // Reset in the fifth HIGH cycle, then a normal pixel.
        pixel_data  = 24'hFFFFFF;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t5_sdi_pre", sdi, 1);
        reset = 1'b1;
        chk("t5_rdy_rst", pixel_ready, 0);
        tick();
        chk("t5_sdi_rst", sdi, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_cnt_rst", pixel_count, 0);
        chk("t5_ur_rst", underrun_count, 0);
        reset = 1'b0;
        tick();
        chk("t5_rdy", pixel_ready, 1);
        pixel_data  = 24'h81C3E7;
        pixel_valid = 1'b1;
        tick();
        pixel_valid = 1'b0;
        check_pixel(24'h81C3E7, 1'b1, 1'b0, 24'h0, -1, "t5_px");
        chk("t5_cnt", pixel_count, 1);
        chk("t5_ur", underrun_count, UR_STEP);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
